// File: rtl/deflate_pkg.sv
// Shared constants and FSM state type for the fixed-Huffman DEFLATE datapath
// (bit packer and literal/length encoder).
package deflate_pkg;

  localparam int CODE_WIDTH = 18;
  localparam int ACC_WIDTH  = 32;
  localparam int LEN_W      = 5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } pk_state_e;

endpackage

// File: rtl/deflate_bit_packer.sv
// LSB-first bit packer: merges variable-length codes into a byte stream and
// drains/zero-pads the final partial byte on flush.
module deflate_bit_packer #(
  parameter int CODE_WIDTH = deflate_pkg::CODE_WIDTH,
  parameter int ACC_WIDTH  = deflate_pkg::ACC_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          code_valid_in,
  input  logic [CODE_WIDTH-1:0]         code_data_in,
  input  logic [deflate_pkg::LEN_W-1:0] code_len_in,
  output logic                          code_ready_out,
  input  logic                          flush_in,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          flush_done_out
);
  import deflate_pkg::*;

  logic [ACC_WIDTH-1:0] r_acc;
  logic [5:0]           r_bit_cnt;
  pk_state_e            r_state;

  logic                 w_emit;
  logic                 w_partial;
  logic                 w_acc_en;
  logic                 w_flush_acc;
  logic [5:0]           w_base;
  logic [ACC_WIDTH-1:0] w_acc_sh;
  logic [ACC_WIDTH-1:0] w_nxt_acc;
  logic [5:0]           w_nxt_cnt;

  // Mask the code to its valid length and OR it in above the live bits.
  function automatic logic [ACC_WIDTH-1:0] merge_code(
    input logic [ACC_WIDTH-1:0]  acc,
    input logic [CODE_WIDTH-1:0] code,
    input logic [LEN_W-1:0]      len,
    input logic [5:0]            pos
  );
    logic [ACC_WIDTH-1:0] mask;
    mask = (ACC_WIDTH'(1) << len) - ACC_WIDTH'(1);
    return acc | ((ACC_WIDTH'(code) & mask) << pos);
  endfunction

  assign code_ready_out = (r_state == ST_RUN) &&
                          (r_bit_cnt <= 6'(ACC_WIDTH - CODE_WIDTH));
  assign w_partial      = (r_state == ST_FLUSH) && (r_bit_cnt != 6'd0) &&
                          (r_bit_cnt < 6'd8);
  assign out_valid      = (r_bit_cnt >= 6'd8) || w_partial;
  assign out_data       = r_acc[7:0];
  assign out_last       = (r_state == ST_FLUSH) && (r_bit_cnt != 6'd0) &&
                          (r_bit_cnt <= 6'd8);
  assign flush_done_out = (r_state == ST_DONE);

  assign w_emit      = out_valid && out_ready;
  assign w_acc_en    = code_valid_in && code_ready_out && !flush_in;
  assign w_flush_acc = flush_in && code_ready_out;

  always_comb begin
    w_base   = r_bit_cnt;
    w_acc_sh = r_acc;
    if (w_emit && w_partial) begin
      w_base   = 6'd0;
      w_acc_sh = '0;
    end else if (w_emit) begin
      w_base   = r_bit_cnt - 6'd8;
      w_acc_sh = r_acc >> 8;
    end
    w_nxt_acc = w_acc_sh;
    w_nxt_cnt = w_base;
    if (w_acc_en) begin
      w_nxt_acc = merge_code(w_acc_sh, code_data_in, code_len_in, w_base);
      w_nxt_cnt = w_base + 6'(code_len_in);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_bit_cnt <= '0;
      r_state   <= ST_RUN;
    end else begin
      r_acc     <= w_nxt_acc;
      r_bit_cnt <= w_nxt_cnt;
      case (r_state)
        ST_RUN: begin
          // An empty accumulator has nothing to drain, so skip FLUSH entirely.
          if (w_flush_acc)
            r_state <= (w_nxt_cnt == 6'd0) ? ST_DONE : ST_FLUSH;
        end
        ST_FLUSH: begin
          if (w_nxt_cnt == 6'd0)
            r_state <= ST_DONE;
        end
        ST_DONE:  r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && w_acc_en)
      assert (int'(code_len_in) <= CODE_WIDTH);
  end
`endif

endmodule

// File: tb/tb_deflate_bit_packer.sv
// Directed-vector bench for deflate_bit_packer with hand-computed bytes.
module tb_deflate_bit_packer;
  import deflate_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  code_valid_in;
  logic [CODE_WIDTH-1:0] code_data_in;
  logic [LEN_W-1:0]      code_len_in;
  logic                  code_ready_out;
  logic                  flush_in;
  logic [7:0]            out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  flush_done_out;

  int n_tot = 0;
  int n_bad = 0;

  deflate_bit_packer dut (
    .clk            (clk),
    .rst            (rst),
    .code_valid_in  (code_valid_in),
    .code_data_in   (code_data_in),
    .code_len_in    (code_len_in),
    .code_ready_out (code_ready_out),
    .flush_in       (flush_in),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .flush_done_out (flush_done_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive inputs at the falling edge; outputs are sampled at the same point.
  task automatic drv(input logic v, input logic [CODE_WIDTH-1:0] d,
                     input logic [LEN_W-1:0] l, input logic f, input logic r);
    @(negedge clk);
    code_valid_in = v;
    code_data_in  = d;
    code_len_in   = l;
    flush_in      = f;
    out_ready     = r;
  endtask

  initial begin
    rst = 1'b1;
    code_valid_in = 1'b0; code_data_in = '0; code_len_in = '0;
    flush_in = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", code_ready_out, 1);
    chk("rst_fdone", flush_done_out, 0);
    chk("rst_last",  out_last, 0);
    rst = 1'b0;

    // distance-9 code then 3 ones -> 0x8C, flush leaves 0x03
    drv(1, 18'h0C, 5'd7, 0, 1);
    chk("t1_ready0", code_ready_out, 1);
    drv(1, 18'h1F, 5'd3, 0, 1);
    chk("t1_novalid", out_valid, 0);
    drv(0, 18'h0, 5'd0, 0, 1);
    chk("t1_valid", out_valid, 1);
    chk("t1_byte", out_data, 8'h8C);
    chk("t1_nolast", out_last, 0);
    drv(0, 18'h0, 5'd0, 1, 1);
    chk("t1_rem_novalid", out_valid, 0);
    drv(0, 18'h0, 5'd0, 0, 1);
    chk("t1_fl_valid", out_valid, 1);
    chk("t1_fl_byte", out_data, 8'h03);
    chk("t1_fl_last", out_last, 1);
    chk("t1_fl_noready", code_ready_out, 0);
    drv(0, 18'h0, 5'd0, 0, 1);
    chk("t1_fdone", flush_done_out, 1);
    chk("t1_done_novalid", out_valid, 0);
    drv(0, 18'h0, 5'd0, 0, 1);
    chk("t1_fdone_low", flush_done_out, 0);
    chk("t1_ready_again", code_ready_out, 1);

    // backpressure with an 18-bit all-ones code
    drv(1, 18'h3FFFF, 5'd18, 0, 0);
    chk("t2_ready0", code_ready_out, 1);
    drv(0, 18'h0, 5'd0, 0, 0);
    chk("t2_ready_drop", code_ready_out, 0);
    chk("t2_valid", out_valid, 1);
    chk("t2_byte", out_data, 8'hFF);
    drv(0, 18'h0, 5'd0, 0, 1);
    chk("t2_hold_byte", out_data, 8'hFF);
    chk("t2_hold_valid", out_valid, 1);
    chk("t2_hold_last", out_last, 0);
    drv(0, 18'h0, 5'd0, 0, 1);
    chk("t2_byte2", out_data, 8'hFF);
    chk("t2_ready_back", code_ready_out, 1);
    drv(0, 18'h0, 5'd0, 1, 1);
    chk("t2_rem_novalid", out_valid, 0);
    drv(0, 18'h0, 5'd0, 0, 1);
    chk("t2_fl_byte", out_data, 8'h03);
    chk("t2_fl_last", out_last, 1);
    drv(0, 18'h0, 5'd0, 0, 1);
    chk("t2_fdone", flush_done_out, 1);

    // emit 0xA5 and accept 0x15/5 in the same cycle
    drv(1, 18'hA5, 5'd8, 0, 0);
    drv(1, 18'h15, 5'd5, 0, 1);
    chk("t3_byte", out_data, 8'hA5);
    chk("t3_valid", out_valid, 1);
    chk("t3_ready", code_ready_out, 1);
    drv(1, 18'h3FFF8, 5'd3, 0, 1);
    chk("t3_cnt5_novalid", out_valid, 0);
    drv(0, 18'h0, 5'd0, 0, 1);
    chk("t3_merge_byte", out_data, 8'h15);
    chk("t3_merge_valid", out_valid, 1);
    drv(0, 18'h0, 5'd0, 0, 1);
    chk("t3_drained", out_valid, 0);

    // zero-length code, then flush of an empty accumulator
    drv(1, 18'h3FFFF, 5'd0, 0, 1);
    drv(0, 18'h0, 5'd0, 1, 1);
    chk("t4_len0_novalid", out_valid, 0);
    drv(0, 18'h0, 5'd0, 0, 1);
    chk("t4_fdone", flush_done_out, 1);
    chk("t4_novalid", out_valid, 0);
    chk("t4_nolast", out_last, 0);
    drv(1, 18'h5A, 5'd8, 0, 1);
    chk("t4_ready", code_ready_out, 1);
    chk("t4_fdone_low", flush_done_out, 0);
    drv(0, 18'h0, 5'd0, 0, 1);
    chk("t4_byte", out_data, 8'h5A);
    chk("t4_valid", out_valid, 1);

    // reset with 11 bits buffered
    drv(1, 18'h7FF, 5'd11, 0, 0);
    drv(0, 18'h0, 5'd0, 0, 0);
    chk("t5_pre_valid", out_valid, 1);
    rst = 1'b1;
    drv(0, 18'h0, 5'd0, 0, 1);
    rst = 1'b0;
    chk("t5_rst_novalid", out_valid, 0);
    chk("t5_rst_ready", code_ready_out, 1);
    code_valid_in = 1'b1; code_data_in = 18'h01; code_len_in = 5'd8;
    drv(0, 18'h0, 5'd0, 0, 1);
    chk("t5_byte", out_data, 8'h01);
    chk("t5_valid", out_valid, 1);
    chk("t5_nolast", out_last, 0);
    drv(0, 18'h0, 5'd0, 0, 1);
    chk("t5_drained", out_valid, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/deflate_bit_packer.md
# deflate_bit_packer

Packs the variable-length codes of the fixed-Huffman DEFLATE encoder into an LSB-first byte stream per RFC 1951. It sits directly downstream of the static distance Huffman tree and the literal/length encoder and takes `{extra bits, reversed Huffman code}` words plus a valid-bit count. It emits bytes toward the output FIFO/AXI writer over a valid/ready handshake. A flush request pads the final partial byte with zeros and marks the end of the stream.

## Interface
- `CODE_WIDTH`, 18: width of `code_data_in`; max legal `code_len_in`.
- `ACC_WIDTH`, 32: bit accumulator width; must be ≥ `CODE_WIDTH` + 8.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `code_valid_in`  in  1  a code is presented.
- `code_data_in`  in  CODE_WIDTH  code bits; bit 0 is transmitted first; bits at or above `code_len_in` are ignored (masked).
- `code_len_in`  in  5  number of valid bits, 0..CODE_WIDTH.
- `code_ready_out`  out  1  packer accepts a code or flush this cycle.
- `flush_in`  in  1  end-of-stream request; handshakes with `code_ready_out` like a code.
- `out_data`  out  8  packed byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer takes the byte.
- `out_last`  out  1  qualifies the final byte of a flushed stream.
- `flush_done_out`  out  1  one-cycle pulse when the flush drain completes.

## Operation
- State: `acc[ACC_WIDTH-1:0]`, `bit_cnt[5:0]`, FSM {RUN, FLUSH, DONE}.
- Reset: `acc`=0, `bit_cnt`=0, state RUN. Outputs: `out_valid`=0, `out_last`=0, `flush_done_out`=0, `code_ready_out`=1.
- `code_ready_out` = (state==RUN) && (`bit_cnt` ≤ ACC_WIDTH−CODE_WIDTH), i.e. `bit_cnt` ≤ 14. It depends on registers only, with no path from `code_len_in`.
- Emit `emit` = `out_valid` && `out_ready`. `out_data` = `acc[7:0]`.
- `out_valid` = (`bit_cnt` ≥ 8) || (state==FLUSH && 0 < `bit_cnt` < 8).
- Accept `acc_en` = `code_valid_in` && `code_ready_out` && !`flush_in`.
- Next state per cycle, for an emit and an accept in the same cycle:
  - `acc` ← (`acc` >> (emit ? 8 : 0)) | (masked code << (`bit_cnt` − (emit ? 8 : 0))).
  - `bit_cnt` ← `bit_cnt` − (emit ? 8 : 0) + (acc_en ? `code_len_in` : 0).
  - When the emitted byte is partial (FLUSH), `bit_cnt` ← 0.
- `code_len_in`=0 is accepted and changes nothing.
- `flush_in` && `code_ready_out`: RUN→FLUSH.
  - A code presented together with `flush_in` is not packed. Upstream sends the last code first.
  - In FLUSH, `code_ready_out`=0 and full bytes drain.
  - The final partial byte is zero-padded in the upper bits, because `acc` above `bit_cnt` is always 0.
- `out_last`=1 on the byte whose emit leaves `bit_cnt`=0 in FLUSH.
- When `bit_cnt` reaches 0 in FLUSH: go to DONE, and `flush_done_out` pulses in the DONE cycle. DONE→RUN on the next cycle, ready for a new stream.
- Flush with `bit_cnt`=0: no byte, no `out_last`; FLUSH→DONE immediately.
- `rst` mid-stream discards all buffered bits; no partial byte is emitted.
- `code_len_in` > CODE_WIDTH is illegal and is flagged by a simulation assertion. Hardware behaviour is undefined.

## Timing
- Code accepted at edge N: its first whole byte is `out_valid` from cycle N+1.
- Throughput: one byte per cycle. Input accepted every cycle while codes average ≤ 8 bits.
- While `out_valid` && !`out_ready`, `out_data` and `out_last` hold stable and `bit_cnt` does not decrease.

## Structure
- Shared package `deflate_pkg`: `CODE_WIDTH`, `ACC_WIDTH`, and a code-length localparam of 5 bits. It also holds the FSM state enum, shared with the literal/length encoder.
- Single module, no sub-module. The masked-shift-merge is an internal function.

## Test plan
- Reset: hold `rst` 2 cycles → `out_valid`=0, `code_ready_out`=1, `flush_done_out`=0.
- Code 0x0C/len 7 (distance 9 from SDHT), then 0x1F/len 3 → byte 0x8C. Then flush → byte 0x03 with `out_last`=1, then `flush_done_out` pulse.
- Backpressure: `out_ready`=0, code 0x3FFFF/len 18 → `code_ready_out` drops the next cycle (`bit_cnt`=18), and `out_data`=0xFF holds stable. Release `out_ready` → bytes 0xFF, 0xFF, then 0x03 on flush with `out_last`.
- Simultaneous event: `bit_cnt`=8 with `acc`=0xA5, `out_ready`=1, code 0x15/len 5 → byte 0xA5 emitted, and the next state is `bit_cnt`=5, `acc`=0x15.
- Empty flush: flush with `bit_cnt`=0 → no `out_valid`, `flush_done_out` pulses, and a code is accepted again afterward.
- Reset mid-operation: `rst` with `bit_cnt`=11 → next cycle `out_valid`=0 and `bit_cnt`=0. Subsequent codes 0x01/len 8 → byte 0x01.
